// File: rtl/pc_ctrl_pkg.sv
// Shared encodings for the fetch-PC controller: PCSel codes, FSM states, reset PC.
package pc_ctrl_pkg;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;

    // PCSel codes consumed by the PC decision datapath
    localparam logic [2:0] PCSEL_SEQ = 3'b000;
    localparam logic [2:0] PCSEL_BR  = 3'b001;
    localparam logic [2:0] PCSEL_JMP = 3'b010;
    localparam logic [2:0] PCSEL_JR  = 3'b011;
    localparam logic [2:0] PCSEL_RST = 3'b100;

    // Controller states
    localparam logic [1:0] S_BOOT = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_PEND = 2'd2;
    localparam logic [1:0] S_HALT = 2'd3;

    // Sequential successor; wraps modulo 2^32
    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/pc_redirect_ctrl_arbiter.sv
// Fixed-priority redirect select: soft_rst > taken branch > jr > jmp.
// When allow_young is low only soft_rst may win (pending fetch, halt, boot).
module redirect_arbiter
    import pc_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
    input  logic        allow_young,
    input  logic        soft_rst,
    input  logic        br_valid,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        jr_valid,
    input  logic [31:0] jr_target,
    input  logic        jmp_valid,
    input  logic [31:0] jmp_target,
    output logic        redir_valid,
    output logic [2:0]  redir_sel,
    output logic [31:0] redir_target,
    output logic        redir_flush_id
);

    // Pick one winner per cycle; a not-taken branch falls through to lower sources
    always_comb begin
        redir_valid    = 1'b0;
        redir_sel      = PCSEL_SEQ;
        redir_target   = 32'd0;
        redir_flush_id = 1'b0;
        if (soft_rst) begin
            redir_valid    = 1'b1;
            redir_sel      = PCSEL_RST;
            redir_target   = RESET_PC;
            redir_flush_id = 1'b1;
        end else if (allow_young && br_valid && br_taken) begin
            redir_valid    = 1'b1;
            redir_sel      = PCSEL_BR;
            redir_target   = br_target;
            redir_flush_id = 1'b1;
        end else if (allow_young && jr_valid) begin
            redir_valid  = 1'b1;
            redir_sel    = PCSEL_JR;
            redir_target = jr_target;
        end else if (allow_young && jmp_valid) begin
            redir_valid  = 1'b1;
            redir_sel    = PCSEL_JMP;
            redir_target = jmp_target;
        end
    end

endmodule

// File: rtl/pc_redirect_ctrl.sv
// Fetch-PC sequencer: owns the PC, drives the imem req/ack fetch and applies redirects.
// Handshake: fetch_req/fetch_addr stay stable from assertion until the cycle fetch_ack
// is high; a redirect arriving while a request is outstanding is parked in pend_pc.
module pc_redirect_ctrl
    import pc_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             halt,
    input  logic             soft_rst,
    input  logic             br_valid,
    input  logic             br_taken,
    input  logic [31:0]      br_target,
    input  logic             jr_valid,
    input  logic [31:0]      jr_target,
    input  logic             jmp_valid,
    input  logic [31:0]      jmp_target,
    output logic             fetch_req,
    output logic [31:0]      fetch_addr,
    input  logic             fetch_ack,
    output logic [31:0]      pc,
    output logic [2:0]       pc_sel,
    output logic             if_flush,
    output logic             id_flush,
    output logic [CNT_W-1:0] redirect_cnt
);

    logic [1:0]       state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      pend_pc_q, pend_pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic        redir_valid;
    logic [2:0]  redir_sel;
    logic [31:0] redir_target;
    logic        redir_flush_id;

    redirect_arbiter #(.RESET_PC(RESET_PC)) u_arb (
        .allow_young    (state_q == S_RUN),
        .soft_rst       (soft_rst),
        .br_valid       (br_valid),
        .br_taken       (br_taken),
        .br_target      (br_target),
        .jr_valid       (jr_valid),
        .jr_target      (jr_target),
        .jmp_valid      (jmp_valid),
        .jmp_target     (jmp_target),
        .redir_valid    (redir_valid),
        .redir_sel      (redir_sel),
        .redir_target   (redir_target),
        .redir_flush_id (redir_flush_id)
    );

    // Output decode; reset forces the reset code and both flushes
    always_comb begin
        fetch_req    = rst_n && (((state_q == S_RUN) && !stall) || (state_q == S_PEND));
        fetch_addr   = pc_q;
        pc           = pc_q;
        pc_sel       = rst_n ? redir_sel : PCSEL_RST;
        if_flush     = !rst_n || redir_valid || ((state_q == S_PEND) && fetch_ack);
        id_flush     = !rst_n || redir_flush_id;
        redirect_cnt = cnt_q;
    end

    // Next-state, next-PC and statistics
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        pend_pc_d = pend_pc_q;
        cnt_d     = cnt_q;
        if (redir_valid && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
        case (state_q)
            S_BOOT: begin
                if (redir_valid) pc_d = redir_target;
                state_d = S_RUN;
            end
            S_RUN: begin
                if (redir_valid) begin
                    if (fetch_req && !fetch_ack) begin
                        pend_pc_d = redir_target;
                        state_d   = S_PEND;
                    end else begin
                        pc_d = redir_target;
                    end
                end else if (fetch_req && fetch_ack) begin
                    pc_d = pc_plus4(pc_q);
                    if (halt) state_d = S_HALT;
                end else if (!fetch_req && halt) begin
                    state_d = S_HALT;
                end
            end
            S_PEND: begin
                if (redir_valid) pend_pc_d = redir_target;
                if (fetch_ack) begin
                    pc_d    = redir_valid ? redir_target : pend_pc_q;
                    state_d = S_RUN;
                end
            end
            default: begin
                if (redir_valid) begin
                    pc_d    = redir_target;
                    state_d = S_RUN;
                end
            end
        endcase
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_BOOT;
            pc_q      <= RESET_PC;
            pend_pc_q <= 32'd0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            pend_pc_q <= pend_pc_d;
            cnt_q     <= cnt_d;
        end
    end

endmodule
